lbuf_scan: RTL and testbench
============================

LBUF_SCAN -- requirements
Module: lbuf_scan

Interface
REQ-001 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 resetl  in  1  reset, synchronous, active-low.
REQ-003 pix_en  in  1  pixel-clock strobe, one sys_clk wide; one pixel is consumed per strobe.
REQ-004 hstart  in  1  one-cycle pulse marking the start of a display line.
REQ-005 vactive  in  1  vertical active; qualifies hstart.
REQ-006 hwidth  in  10  pixels per line, 0..1023; sampled at hstart.
REQ-007 bigend  in  1  1: first pixel is lbrd[31:16]; 0: first pixel is lbrd[15:0].
REQ-008 lbrd  in  32  line-buffer read data; valid one sys_clk after lbra changes.
REQ-009 lbra  out  9  line-buffer read/clear word address.
REQ-010 lbufa / lbufb  out  1 each  display-side select; always complementary.
REQ-011 bgw  out  1  one-cycle background-clear strobe for the word at lbra.
REQ-012 pix / pix_valid  out  16 / 1  pixel output and its qualifier.
REQ-013 underrun  out  1  sticky flag: a pix_en strobe arrived with no pixel ready.

Function
REQ-014 States: IDLE, FETCH, LOAD, SHOW, CLEAR.
REQ-015 IDLE, hstart=1, vactive=1:
- toggle lbufa/lbufb;
- latch hwidth into the remaining-pixel counter (rem);
- lbra=0, clear underrun;
- go to FETCH, or stay in IDLE if hwidth=0 (the swap still occurs).
REQ-016 hstart=1 with vactive=0: no swap, no state change, no bgw.
REQ-017 FETCH: hold lbra for one cycle, then go to LOAD.
REQ-018 LOAD: capture lbrd into a 32-bit word register, clear the half pointer, go to SHOW.
REQ-019 SHOW, on pix_en:
- pix = current half selected by bigend and the half pointer; pix_valid=1 for that cycle;
- rem decrements by 1; the half pointer toggles.
REQ-020 SHOW exits to CLEAR after the second half is emitted, or after the first half if rem reaches 0 (odd hwidth).
REQ-021 CLEAR: bgw=1 for one cycle with lbra still at the consumed word.
- Next cycle: if rem=0, go to IDLE with lbra held; else lbra+1 and go to FETCH.
REQ-022 lbra wraps 511->0 without error; no more than 512 words are read per line.
REQ-023 pix holds its last value while pix_valid=0; pix_valid is never high outside SHOW.
REQ-024 pix_en in FETCH, LOAD or CLEAR while rem>0:
- set underrun; pix_valid=0; rem unchanged (the pixel is dropped, not skipped).
REQ-025 pix_en in IDLE has no effect.
REQ-026 Required pix_en spacing is at least 4 sys_clk at word boundaries.
REQ-027 hstart in any non-IDLE state with vactive=1:
- abort the line with no bgw for the partial word;
- perform the REQ-015 actions the same cycle.
REQ-028 hstart in a non-IDLE state with vactive=0: abort to IDLE, no swap.
REQ-029 bgw is only ever asserted in CLEAR.

Reset
REQ-030 resetl=0 at a clock edge forces, whatever the current state:
- state=IDLE, lbra=0, lbufa=1, lbufb=0;
- bgw=0, pix=0, pix_valid=0, underrun=0, rem=0, word register=0.
REQ-031 The first edge with resetl=1 behaves as IDLE; an hstart on that edge is honoured.

Verification
REQ-032 Reset, then hstart (vactive=1), hwidth=4, bigend=1, lbrd word0=0x11112222, word1=0x33334444, pix_en every 6 clocks:
- pix sequence 1111, 2222, 3333, 4444;
- bgw at lbra=0 then at lbra=1;
- lbufa=0 after the swap; returns to IDLE.
REQ-033 Same as REQ-032 with bigend=0: pix sequence 2222, 1111, 4444, 3333.
REQ-034 hwidth=3: three pixels emitted; bgw for words 0 and 1 only; rem=0; IDLE with lbra=1.
REQ-035 pix_en two clocks after the second pixel of word0: underrun=1, pix_valid=0, and the next valid pixel is word1's first half.
REQ-036 hstart mid-word: no bgw for that word; lbufa toggles; lbra=0; underrun clears.
- Repeat with vactive=0: goes to IDLE, lbufa unchanged.
REQ-037 resetl low during SHOW: next cycle all REQ-030 values hold; hstart with hwidth=0 toggles lbufa only, with no FETCH and no bgw.

Source files
------------

// File: rtl/lbuf_scan.sv
// lbuf_scan -- display-side line-buffer scanner.
//
// Once a line starts, it reads 32-bit words from the line buffer. Each word
// is split into two 16-bit pixels, and one pixel is emitted per pix_en
// strobe. After both halves of a word are shown, the word is cleared to
// background (bgw) so the buffer can be reused on the next line. The two
// line buffers swap roles at every qualified line start.
//
// Ports:
//   sys_clk    in   sole clock, rising edge
//   resetl     in   synchronous active-low reset
//   pix_en     in   pixel strobe, one pixel consumed per strobe
//   hstart     in   line-start pulse, qualified by vactive
//   vactive    in   vertical active
//   hwidth     in   pixels per line (sampled at a qualified hstart)
//   bigend     in   1: first pixel is lbrd[31:16]; 0: first pixel is lbrd[15:0]
//   lbrd       in   line-buffer read data, valid one clock after lbra changes
//   lbra       out  line-buffer read/clear word address
//   lbufa/b    out  display-side buffer select (complementary)
//   bgw        out  background-clear strobe for the word at lbra
//   pix        out  pixel data (holds while pix_valid is low)
//   pix_valid  out  pixel qualifier
//   underrun   out  sticky: a strobe arrived with no pixel ready
module lbuf_scan (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        pix_en,
    input  logic        hstart,
    input  logic        vactive,
    input  logic [9:0]  hwidth,
    input  logic        bigend,
    input  logic [31:0] lbrd,
    output logic [8:0]  lbra,
    output logic        lbufa,
    output logic        lbufb,
    output logic        bgw,
    output logic [15:0] pix,
    output logic        pix_valid,
    output logic        underrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHOW  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  rem_reg, rem_next;
    logic [8:0]  lbra_reg, lbra_next;
    logic [31:0] word_reg, word_next;
    logic        half_reg, half_next;
    logic        lbufa_reg, lbufa_next;
    logic        underrun_reg, underrun_next;
    logic [15:0] pix_reg, pix_next;

    logic [15:0] cur_half;
    logic        line_start;
    logic        line_abort;
    logic        emit;
    logic        starved;

    // bigend picks which half goes first; the half pointer flips it for
    // the second pixel of the word.
    assign cur_half = (bigend ^ half_reg) ? word_reg[31:16] : word_reg[15:0];

    // A qualified hstart restarts the line from any state. An unqualified
    // hstart only matters when a line is in progress, and it aborts that line.
    assign line_start = hstart & vactive;
    assign line_abort = hstart & ~vactive & (state_reg != IDLE);

    // A pixel leaves only in SHOW. An hstart in the same cycle wins, because
    // the line it belongs to is being abandoned.
    assign emit = (state_reg == SHOW) & pix_en & ~hstart;

    // A strobe while the next word is still in flight means that pixel is lost.
    assign starved = pix_en & (rem_reg != 10'd0);

    always_comb begin
        state_next    = state_reg;
        rem_next      = rem_reg;
        lbra_next     = lbra_reg;
        word_next     = word_reg;
        half_next     = half_reg;
        lbufa_next    = lbufa_reg;
        underrun_next = underrun_reg;
        pix_next      = pix_reg;

        if (line_start) begin
            lbufa_next    = ~lbufa_reg;
            rem_next      = hwidth;
            lbra_next     = 9'd0;
            underrun_next = 1'b0;
            half_next     = 1'b0;
            state_next    = (hwidth == 10'd0) ? IDLE : FETCH;
        end else if (line_abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                FETCH: begin
                    if (starved) begin
                        underrun_next = 1'b1;
                    end
                    state_next = LOAD;
                end
                LOAD: begin
                    if (starved) begin
                        underrun_next = 1'b1;
                    end
                    word_next  = lbrd;
                    half_next  = 1'b0;
                    state_next = SHOW;
                end
                SHOW: begin
                    if (emit) begin
                        pix_next  = cur_half;
                        rem_next  = rem_reg - 10'd1;
                        half_next = ~half_reg;
                        // Leave after the second half, or early when an odd
                        // line width runs out on the first half.
                        if (half_reg || (rem_reg == 10'd1)) begin
                            state_next = CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    if (starved) begin
                        underrun_next = 1'b1;
                    end
                    if (rem_reg == 10'd0) begin
                        state_next = IDLE;
                    end else begin
                        // 9-bit address wraps 511 -> 0 on its own.
                        lbra_next  = lbra_reg + 9'd1;
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_reg    <= IDLE;
            rem_reg      <= 10'd0;
            lbra_reg     <= 9'd0;
            word_reg     <= 32'd0;
            half_reg     <= 1'b0;
            lbufa_reg    <= 1'b1;
            underrun_reg <= 1'b0;
            pix_reg      <= 16'd0;
        end else begin
            state_reg    <= state_next;
            rem_reg      <= rem_next;
            lbra_reg     <= lbra_next;
            word_reg     <= word_next;
            half_reg     <= half_next;
            lbufa_reg    <= lbufa_next;
            underrun_reg <= underrun_next;
            pix_reg      <= pix_next;
        end
    end

    assign lbra      = lbra_reg;
    assign lbufa     = lbufa_reg;
    assign lbufb     = ~lbufa_reg;
    assign bgw       = (state_reg == CLEAR);
    assign pix_valid = emit;
    // The pixel is presented in the strobe cycle itself. Otherwise pix shows
    // the last pixel emitted.
    assign pix       = emit ? cur_half : pix_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_lbuf_scan.sv
module tb_lbuf_scan;

    logic        sys_clk;
    logic        resetl;
    logic        pix_en;
    logic        hstart;
    logic        vactive;
    logic [9:0]  hwidth;
    logic        bigend;
    logic [31:0] lbrd;
    logic [8:0]  lbra;
    logic        lbufa;
    logic        lbufb;
    logic        bgw;
    logic [15:0] pix;
    logic        pix_valid;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    logic [15:0] pix_q[$];
    logic [8:0]  bgw_q[$];
    logic [31:0] mem [0:511];
    logic        exp_a;

    lbuf_scan dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .pix_en    (pix_en),
        .hstart    (hstart),
        .vactive   (vactive),
        .hwidth    (hwidth),
        .bigend    (bigend),
        .lbrd      (lbrd),
        .lbra      (lbra),
        .lbufa     (lbufa),
        .lbufb     (lbufb),
        .bgw       (bgw),
        .pix       (pix),
        .pix_valid (pix_valid),
        .underrun  (underrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Line-buffer model: data valid one clock after the address changes.
    always @(posedge sys_clk) lbrd <= mem[lbra];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pixels and clear strobes are compared as the DUT produces them.
    always @(negedge sys_clk) begin
        if (pix_valid === 1'b1) begin
            if (pix_q.size() == 0) begin
                check("pix_unexpected", {15'd0, pix_valid}, 32'd0);
            end else begin
                logic [15:0] e;
                e = pix_q.pop_front();
                $display("pix %h expected %h", pix, e);
                check("pix", {16'd0, pix}, {16'd0, e});
            end
        end
        if (bgw === 1'b1) begin
            if (bgw_q.size() == 0) begin
                check("bgw_unexpected", {31'd0, bgw}, 32'd0);
            end else begin
                logic [8:0] a;
                a = bgw_q.pop_front();
                $display("bgw at lbra %0d expected %0d", lbra, a);
                check("bgw_addr", {23'd0, lbra}, {23'd0, a});
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic strobe();
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
    endtask

    task automatic start_line(input logic [9:0] w, input logic be);
        hstart  = 1'b1;
        vactive = 1'b1;
        hwidth  = w;
        bigend  = be;
        tick();
        hstart  = 1'b0;
        exp_a   = ~exp_a;
    endtask

    task automatic show_pix(input logic [15:0] e);
        repeat (5) tick();
        pix_q.push_back(e);
        strobe();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lbra"},     {23'd0, lbra}, 32'd0);
        check({tag, "_lbufa"},    {31'd0, lbufa}, 32'd1);
        check({tag, "_lbufb"},    {31'd0, lbufb}, 32'd0);
        check({tag, "_bgw"},      {31'd0, bgw}, 32'd0);
        check({tag, "_pix"},      {16'd0, pix}, 32'd0);
        check({tag, "_pixvalid"}, {31'd0, pix_valid}, 32'd0);
        check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        mem[0] = 32'h11112222;
        mem[1] = 32'h33334444;
        mem[2] = 32'h55556666;
        resetl = 1'b0; pix_en = 1'b0; hstart = 1'b0; vactive = 1'b0;
        hwidth = 10'd0; bigend = 1'b1; exp_a = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        resetl = 1'b1;
        tick();

        // Big-endian 4-pixel line.
        bgw_q.push_back(9'd0); bgw_q.push_back(9'd1);
        start_line(10'd4, 1'b1);
        check("be_lbufa", {31'd0, lbufa}, {31'd0, exp_a});
        check("be_lbufb", {31'd0, lbufb}, {31'd0, ~exp_a});
        check("be_lbra0", {23'd0, lbra}, 32'd0);
        show_pix(16'h1111); show_pix(16'h2222);
        show_pix(16'h3333); show_pix(16'h4444);
        tick(); tick();
        check("be_lbra_end", {23'd0, lbra}, 32'd1);
        check("be_pix_hold", {16'd0, pix}, 32'h4444);
        strobe();   // IDLE: no effect
        check("idle_strobe_underrun", {31'd0, underrun}, 32'd0);

        // Unqualified hstart in IDLE: no swap.
        hstart = 1'b1; vactive = 1'b0; tick(); hstart = 1'b0;
        check("novact_idle_lbufa", {31'd0, lbufa}, {31'd0, exp_a});

        // Little-endian 4-pixel line.
        bgw_q.push_back(9'd0); bgw_q.push_back(9'd1);
        start_line(10'd4, 1'b0);
        check("le_lbufa", {31'd0, lbufa}, {31'd0, exp_a});
        show_pix(16'h2222); show_pix(16'h1111);
        show_pix(16'h4444); show_pix(16'h3333);
        tick(); tick();
        check("le_lbra_end", {23'd0, lbra}, 32'd1);

        // Odd width: 3 pixels, two clears.
        bgw_q.push_back(9'd0); bgw_q.push_back(9'd1);
        start_line(10'd3, 1'b1);
        show_pix(16'h1111); show_pix(16'h2222); show_pix(16'h3333);
        tick(); tick();
        check("odd_lbra_end", {23'd0, lbra}, 32'd1);
        check("odd_pix_hold", {16'd0, pix}, 32'h3333);
        strobe();
        check("odd_idle_underrun", {31'd0, underrun}, 32'd0);

        // Underrun at a word boundary: the dropped pixel is not skipped.
        bgw_q.push_back(9'd0); bgw_q.push_back(9'd1);
        start_line(10'd4, 1'b1);
        show_pix(16'h1111); show_pix(16'h2222);
        tick();
        pix_en = 1'b1;
        #2;
        check("urun_pixvalid", {31'd0, pix_valid}, 32'd0);
        tick();
        pix_en = 1'b0;
        check("urun_set", {31'd0, underrun}, 32'd1);
        show_pix(16'h3333); show_pix(16'h4444);
        tick(); tick();
        check("urun_sticky", {31'd0, underrun}, 32'd1);
        check("urun_lbra_end", {23'd0, lbra}, 32'd1);

        // Mid-word qualified hstart: no clear for the partial word.
        start_line(10'd4, 1'b1);
        check("mid_urun_cleared", {31'd0, underrun}, 32'd0);
        strobe();   // FETCH starve
        check("mid_urun_set", {31'd0, underrun}, 32'd1);
        show_pix(16'h1111);
        bgw_q.push_back(9'd0); bgw_q.push_back(9'd1); bgw_q.push_back(9'd2);
        start_line(10'd6, 1'b1);
        check("mid_lbufa", {31'd0, lbufa}, {31'd0, exp_a});
        check("mid_lbra", {23'd0, lbra}, 32'd0);
        check("mid_underrun", {31'd0, underrun}, 32'd0);
        show_pix(16'h1111); show_pix(16'h2222);
        show_pix(16'h3333); show_pix(16'h4444);
        show_pix(16'h5555); show_pix(16'h6666);
        tick(); tick();
        check("mid_lbra_end", {23'd0, lbra}, 32'd2);

        // Mid-word unqualified hstart: abort, no swap.
        start_line(10'd4, 1'b1);
        show_pix(16'h1111);
        hstart = 1'b1; vactive = 1'b0; tick(); hstart = 1'b0;
        check("abort_lbufa", {31'd0, lbufa}, {31'd0, exp_a});
        check("abort_lbra", {23'd0, lbra}, 32'd0);
        repeat (3) tick();
        strobe();
        check("abort_underrun", {31'd0, underrun}, 32'd0);

        // Reset during SHOW, then a zero-width line on the first live edge.
        start_line(10'd4, 1'b1);
        show_pix(16'h1111);
        resetl = 1'b0;
        tick();
        check_reset_values("rst_show");
        exp_a = 1'b1;
        resetl = 1'b1;
        start_line(10'd0, 1'b1);
        check("zero_lbufa", {31'd0, lbufa}, {31'd0, exp_a});
        repeat (6) tick();
        strobe();
        check("zero_lbra", {23'd0, lbra}, 32'd0);
        check("zero_underrun", {31'd0, underrun}, 32'd0);
        tick();

        check("pix_q_empty", pix_q.size(), 32'd0);
        check("bgw_q_empty", bgw_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
